// File: rtl/pixel_addr_gen.sv
// Raster-order read address generator and filtered-output write address tracker
// for a single image job kicked off by a rising edge on final_enable.
module pixel_addr_gen #(
  parameter int ADDR_W    = 32,
  parameter int ADDR_STEP = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [ADDR_W-1:0] width,
  input  logic [ADDR_W-1:0] height,
  input  logic [ADDR_W-1:0] readStartAddress,
  input  logic [ADDR_W-1:0] writeStartAddress,
  input  logic              final_enable,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_row_end,
  input  logic              wr_next,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              busy,
  output logic              done,
  output logic              cfg_error
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DONE, ERR} state_t;

  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(ADDR_STEP);
  localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] THREE = ADDR_W'(3);

  state_t            state, state_nxt;
  logic              fe_q, armed, start, cfg_bad;
  logic [ADDR_W-1:0] width_q, height_q;
  logic [ADDR_W-1:0] col, row, wcol, wrow;
  logic              rd_done, wr_done;
  logic              rd_xfer, rd_last, wr_acc, wr_last;
  logic              rd_fin, wr_fin;

  // armed stays low until final_enable is seen low, so a level held through reset never starts a job
  assign start   = final_enable & ~fe_q & armed;
  assign cfg_bad = (width < THREE) || (height < THREE);

  assign rd_valid   = (state == RUN) && !rd_done;
  assign rd_xfer    = rd_valid && rd_ready;
  assign rd_row_end = rd_valid && (col == width_q - ONE);
  assign rd_last    = rd_xfer && (col == width_q - ONE) && (row == height_q - ONE);

  // the filter output grid is (width-2) x (height-2); nested counters avoid a multiplier
  assign wr_acc  = (state == RUN) && wr_next && !wr_done;
  assign wr_last = wr_acc && (wcol == width_q - THREE) && (wrow == height_q - THREE);

  assign rd_fin = rd_done || rd_last;
  assign wr_fin = wr_done || wr_last;

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign cfg_error = (state == ERR);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      fe_q  <= 1'b0;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      fe_q  <= final_enable;
      armed <= armed | ~final_enable;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = cfg_bad ? ERR : RUN;
      RUN:     if (rd_fin && wr_fin) state_nxt = DONE;
      DONE:    if (!final_enable) state_nxt = IDLE;
      ERR:     if (!final_enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      width_q  <= '0;
      height_q <= '0;
      col      <= '0;
      row      <= '0;
      wcol     <= '0;
      wrow     <= '0;
      rd_done  <= 1'b0;
      wr_done  <= 1'b0;
      rd_addr  <= '0;
      wr_addr  <= '0;
    end else if (state == LOAD) begin
      width_q  <= width;
      height_q <= height;
      col      <= '0;
      row      <= '0;
      wcol     <= '0;
      wrow     <= '0;
      rd_done  <= 1'b0;
      wr_done  <= 1'b0;
      rd_addr  <= readStartAddress;
      wr_addr  <= writeStartAddress;
    end else if (state == RUN) begin
      if (rd_xfer) begin
        rd_addr <= rd_addr + STEP;
        if (col == width_q - ONE) begin
          col <= '0;
          row <= row + ONE;
        end else begin
          col <= col + ONE;
        end
        if (rd_last) rd_done <= 1'b1;
      end
      if (wr_acc) begin
        wr_addr <= wr_addr + STEP;
        if (wcol == width_q - THREE) begin
          wcol <= '0;
          wrow <= wrow + ONE;
        end else begin
          wcol <= wcol + ONE;
        end
        if (wr_last) wr_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pixel_addr_gen.sv
// Directed bench for pixel_addr_gen: a job-level reference model checked every
// cycle, plus hand-computed literal expectations per scenario.
module tb_pixel_addr_gen;

  logic        clk = 1'b0;
  logic        n_rst, final_enable, rd_ready, wr_next;
  logic [31:0] width, height, rs, ws;
  logic        rd_valid, rd_row_end, busy, done, cfg_error;
  logic [31:0] rd_addr, wr_addr;

  int n_pass = 0;
  int n_tot  = 0;
  int k_end;

  logic [31:0] xq[$];
  logic [31:0] req[$];

  pixel_addr_gen #(.ADDR_W(32), .ADDR_STEP(4)) dut (
    .clk(clk), .n_rst(n_rst),
    .width(width), .height(height),
    .readStartAddress(rs), .writeStartAddress(ws),
    .final_enable(final_enable),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_row_end(rd_row_end),
    .wr_next(wr_next), .wr_addr(wr_addr),
    .busy(busy), .done(done), .cfg_error(cfg_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] qget(input int i);
    if (i < xq.size()) return xq[i];
    return 32'hDEADBEEF;
  endfunction

  function automatic logic [31:0] rget(input int i);
    if (i < req.size()) return req[i];
    return 32'hDEADBEEF;
  endfunction

  // Job-level model: phase 0 idle, 1 load, 2 run, 3 done, 4 error.
  // Addresses are start + count*4, independent of how the DUT walks them.
  int          m_ph, m_w, m_h, m_ri, m_wi, m_tot, m_wtot;
  logic        m_armed, m_fe, m_rf, m_wf;
  logic [31:0] m_rs, m_ws;
  logic        e_valid, e_row_end;
  logic [31:0] e_rd, e_wr;

  assign m_tot     = m_w * m_h;
  assign m_wtot    = (m_w - 2) * (m_h - 2);
  assign e_valid   = (m_ph == 2) && (m_ri < m_tot);
  assign m_rf      = e_valid && rd_ready;
  assign m_wf      = (m_ph == 2) && wr_next && (m_wi < m_wtot);
  assign e_row_end = e_valid && (m_w > 0) && ((m_ri % m_w) == m_w - 1);
  assign e_rd      = m_rs + 32'(m_ri * 4);
  assign e_wr      = m_ws + 32'(m_wi * 4);

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_ph <= 0; m_w <= 0; m_h <= 0; m_ri <= 0; m_wi <= 0;
      m_armed <= 1'b0; m_fe <= 1'b0; m_rs <= '0; m_ws <= '0;
    end else begin
      m_armed <= m_armed || !final_enable;
      m_fe    <= final_enable;
      case (m_ph)
        0: if (final_enable && !m_fe && m_armed) m_ph <= 1;
        1: begin
          m_w  <= int'(width);
          m_h  <= int'(height);
          m_rs <= rs;
          m_ws <= ws;
          m_ri <= 0;
          m_wi <= 0;
          m_ph <= (width < 3 || height < 3) ? 4 : 2;
        end
        2: begin
          if (m_rf) m_ri <= m_ri + 1;
          if (m_wf) m_wi <= m_wi + 1;
          if ((m_ri + int'(m_rf)) == m_tot && (m_wi + int'(m_wf)) == m_wtot) m_ph <= 3;
        end
        default: if (!final_enable) m_ph <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("rd_valid", rd_valid, e_valid);
    chk("rd_row_end", rd_row_end, e_row_end);
    chk("rd_addr", rd_addr, e_rd);
    chk("wr_addr", wr_addr, e_wr);
    chk("busy", busy, m_ph == 2);
    chk("done", done, m_ph == 3);
    chk("cfg_error", cfg_error, m_ph == 4);
    if (rd_valid && rd_ready) xq.push_back(rd_addr);
    if (rd_valid && rd_ready && rd_row_end) req.push_back(rd_addr);
  end

  task automatic run_job(input logic [31:0] w, input logic [31:0] h,
                         input logic [31:0] r, input logic [31:0] wa,
                         input logic [3:0] rdy, input logic [63:0] wm,
                         input int drop_k, output int kout);
    width = w; height = h; rs = r; ws = wa;
    xq.delete(); req.delete();
    final_enable = 1'b0;
    step();
    final_enable = 1'b1;
    step();
    chk("lat_load_no_valid", rd_valid, 1'b0);
    step();
    kout = -1;
    for (int k = 0; k < 64; k++) begin
      rd_ready = rdy[k % 4];
      wr_next  = wm[k];
      if (k == drop_k) final_enable = 1'b0;
      step();
      if (done || cfg_error) begin
        kout = k;
        break;
      end
    end
    wr_next  = 1'b0;
    rd_ready = 1'b0;
    chk("job_timeout", kout >= 0, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst = 1'b0; final_enable = 1'b0; rd_ready = 1'b0; wr_next = 1'b0;
    width = '0; height = '0; rs = '0; ws = '0;
    #2;
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_cfg_error", cfg_error, 1'b0);
    chk("rst_rd_addr", rd_addr, 32'h0);
    chk("rst_wr_addr", wr_addr, 32'h0);
    step(); step();
    n_rst = 1'b1;
    step();

    // basic 4x3 job, second write arrives after the reads finish
    run_job(32'd4, 32'd3, 32'h1F4, 32'h157C, 4'b1111, (64'd1 << 3) | (64'd1 << 14), -1, k_end);
    chk("basic_nreads", xq.size(), 12);
    chk("basic_first", qget(0), 32'h1F4);
    chk("basic_last", qget(11), 32'h220);
    chk("basic_nrowend", req.size(), 3);
    chk("basic_rowend0", rget(0), 32'h200);
    chk("basic_rowend1", rget(1), 32'h210);
    chk("basic_rowend2", rget(2), 32'h220);
    chk("basic_wr_addr", wr_addr, 32'h1584);
    chk("basic_done", done, 1'b1);
    chk("basic_busy", busy, 1'b0);
    chk("basic_done_cycle", k_end, 14);
    final_enable = 1'b0;
    step();
    chk("basic_done_clear", done, 1'b0);

    // backpressure 1,0,0,1 with final_enable dropped mid-run
    run_job(32'd4, 32'd3, 32'h1F4, 32'h157C, 4'b1001, (64'd1 << 2) | (64'd1 << 5), 5, k_end);
    chk("bp_nreads", xq.size(), 12);
    for (int i = 1; i < 12; i++) chk("bp_stride", qget(i) - qget(i - 1), 32'd4);
    chk("bp_done_cycle", k_end, 23);
    step();
    chk("bp_done_clear", done, 1'b0);

    // configuration error
    width = 32'd2; height = 32'd5;
    final_enable = 1'b0;
    step();
    final_enable = 1'b1;
    step();
    chk("err_load", cfg_error, 1'b0);
    step();
    chk("err_set", cfg_error, 1'b1);
    chk("err_no_valid", rd_valid, 1'b0);
    step(); step();
    chk("err_held", cfg_error, 1'b1);
    chk("err_no_valid2", rd_valid, 1'b0);
    final_enable = 1'b0;
    step();
    chk("err_clear", cfg_error, 1'b0);

    // three write pulses, first coincident with a read transfer
    run_job(32'd4, 32'd3, 32'h1F4, 32'h157C, 4'b1111,
            (64'd1 << 0) | (64'd1 << 2) | (64'd1 << 5), -1, k_end);
    chk("xw_wr_addr", wr_addr, 32'h1584);
    chk("xw_done_cycle", k_end, 11);
    chk("xw_nreads", xq.size(), 12);
    final_enable = 1'b0;
    step();

    // reset mid-job after five transfers
    width = 32'd4; height = 32'd3; rs = 32'h1F4; ws = 32'h157C;
    xq.delete();
    step();
    final_enable = 1'b1;
    step(); step();
    rd_ready = 1'b1;
    repeat (5) step();
    chk("mid_nreads", xq.size(), 5);
    #2 n_rst = 1'b0;
    #1;
    chk("mid_rst_valid", rd_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_rd_addr", rd_addr, 32'h0);
    chk("mid_rst_wr_addr", wr_addr, 32'h0);
    chk("mid_rst_done", done, 1'b0);
    rd_ready = 1'b0;
    step();
    n_rst = 1'b1;
    repeat (3) step();
    chk("mid_no_level_start", busy, 1'b0);
    run_job(32'd4, 32'd3, 32'h1F4, 32'h157C, 4'b1111, (64'd1 << 0) | (64'd1 << 1), -1, k_end);
    chk("restart_first", qget(0), 32'h1F4);
    chk("restart_nreads", xq.size(), 12);
    final_enable = 1'b0;
    step();

    // address wrap, final_enable held high through reset release
    width = 32'd3; height = 32'd3; rs = 32'hFFFF_FFFC; ws = 32'h100;
    final_enable = 1'b1;
    n_rst = 1'b0;
    step();
    n_rst = 1'b1;
    repeat (3) step();
    chk("lvl_no_busy", busy, 1'b0);
    chk("lvl_no_valid", rd_valid, 1'b0);
    run_job(32'd3, 32'd3, 32'hFFFF_FFFC, 32'h100, 4'b1111, 64'd1, -1, k_end);
    chk("wrap_a0", qget(0), 32'hFFFF_FFFC);
    chk("wrap_a1", qget(1), 32'h0);
    chk("wrap_a2", qget(2), 32'h4);
    chk("wrap_a8", qget(8), 32'h1C);
    chk("wrap_wr_addr", wr_addr, 32'h104);
    chk("wrap_done_cycle", k_end, 8);
    final_enable = 1'b0;
    step();
    chk("wrap_done_clear", done, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
